// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS-subset control unit (fetch/decode/execute sequencer)
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       Of,
    input  logic       Ng,
    input  logic       Zr,
    input  logic       Eq,
    input  logic       Gt,
    input  logic       Lt,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    output logic       PC_w,
    output logic       MEM_w,
    output logic       IR_w,
    output logic       RB_w,
    output logic       AB_w,
    output logic       MDR_w,
    output logic       M_WREG,
    output logic       M_ULAA,
    output logic       IorD,
    output logic       M_REGDATA,
    output logic [1:0] M_ULAB,
    output logic [2:0] ULA_c,
    output logic       halt,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_FWAIT     = 4'd2,
        S_IRLD      = 4'd3,
        S_DECODE    = 4'd4,
        S_EXEC_R    = 4'd5,
        S_EXEC_I    = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_RWAIT = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WR    = 4'd10,
        S_BR_CMP    = 4'd11,
        S_BR_TGT    = 4'd12,
        S_HALT      = 4'd15
    } state_t;
    state_t state;
    logic   take_br;
    logic   is_add, is_sub, is_and;
    logic [2:0] alu_r;
    logic   unused_flags;
    assign unused_flags = ^{Ng, Zr, Gt, Lt};
    assign is_add = FUNCT == 6'h20;
    assign is_sub = FUNCT == 6'h22;
    assign is_and = FUNCT == 6'h24;
    assign alu_r = is_add ? 3'b001 : is_sub ? 3'b010 : is_and ? 3'b011 : 3'b000;
    assign state_dbg = state;
    // state sequencing; branch decision is latched in BR_CMP while the ALU compares A and B
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RESET;
            take_br <= 1'b0;
        end else begin
            case (state)
                S_RESET:     state <= S_FETCH;
                S_FETCH:     state <= S_FWAIT;
                S_FWAIT:     state <= S_IRLD;
                S_IRLD:      state <= S_DECODE;
                S_DECODE:
                    case (OPCODE)
                        6'h00:        state <= S_EXEC_R;
                        6'h08:        state <= S_EXEC_I;
                        6'h23:        state <= S_MEM_ADDR;
                        6'h2B:        state <= S_MEM_WR;
                        6'h04, 6'h05: state <= S_BR_CMP;
                        default:      state <= S_HALT;
                    endcase
                S_EXEC_R:    state <= (is_and || ((is_add || is_sub) && !Of)) ? S_FETCH : S_HALT;
                S_EXEC_I:    state <= Of ? S_HALT : S_FETCH;
                S_MEM_ADDR:  state <= S_MEM_RWAIT;
                S_MEM_RWAIT: state <= S_MEM_WB;
                S_MEM_WB:    state <= S_FETCH;
                S_MEM_WR:    state <= S_FETCH;
                S_BR_CMP: begin
                    take_br <= (OPCODE == 6'h04) ? Eq : ~Eq;
                    state   <= S_BR_TGT;
                end
                S_BR_TGT:    state <= S_FETCH;
                default:     state <= S_HALT;
            endcase
        end
    end
    // datapath controls decoded from the current state; register writes in EXEC_R/EXEC_I are gated by overflow
    always_comb begin
        {PC_w, MEM_w, IR_w, RB_w, AB_w, MDR_w, M_WREG, M_ULAA, IorD, M_REGDATA, halt} = '0;
        M_ULAB = 2'b00;
        ULA_c  = 3'b000;
        case (state)
            S_FETCH: begin
                PC_w   = 1'b1;
                M_ULAB = 2'b01;
                ULA_c  = 3'b001;
            end
            S_IRLD:   IR_w = 1'b1;
            S_DECODE: AB_w = 1'b1;
            S_EXEC_R: begin
                M_ULAA = 1'b1;
                M_WREG = 1'b1;
                ULA_c  = alu_r;
                RB_w   = is_and | ((is_add | is_sub) & ~Of);
            end
            S_EXEC_I: begin
                M_ULAA = 1'b1;
                M_ULAB = 2'b10;
                ULA_c  = 3'b001;
                RB_w   = ~Of;
            end
            S_MEM_ADDR, S_MEM_RWAIT, S_MEM_WR: begin
                IorD   = 1'b1;
                M_ULAA = 1'b1;
                M_ULAB = 2'b10;
                ULA_c  = 3'b001;
                MDR_w  = state == S_MEM_RWAIT;
                MEM_w  = state == S_MEM_WR;
            end
            S_MEM_WB: begin
                M_REGDATA = 1'b1;
                RB_w      = 1'b1;
            end
            S_BR_CMP: begin
                M_ULAA = 1'b1;
                ULA_c  = 3'b111;
            end
            S_BR_TGT: begin
                M_ULAB = 2'b10;
                ULA_c  = 3'b001;
                PC_w   = take_br;
            end
            S_HALT:   halt = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven cycle vectors plus reset/halt corner sequences for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
    logic clk = 1'b0, reset = 1'b1;
    logic Of = 1'b0, Ng = 1'b0, Zr = 1'b0, Eq = 1'b0, Gt = 1'b0, Lt = 1'b0;
    logic [5:0] OPCODE = 6'h3F, FUNCT = 6'h3F;
    logic PC_w, MEM_w, IR_w, RB_w, AB_w, MDR_w, M_WREG, M_ULAA, IorD, M_REGDATA, halt;
    logic [1:0] M_ULAB;
    logic [2:0] ULA_c;
    logic [3:0] state_dbg;
    logic [15:0] outs;
    int tests = 0, fails = 0;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Of(Of), .Ng(Ng), .Zr(Zr), .Eq(Eq), .Gt(Gt), .Lt(Lt),
        .OPCODE(OPCODE), .FUNCT(FUNCT), .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .RB_w(RB_w),
        .AB_w(AB_w), .MDR_w(MDR_w), .M_WREG(M_WREG), .M_ULAA(M_ULAA), .IorD(IorD),
        .M_REGDATA(M_REGDATA), .M_ULAB(M_ULAB), .ULA_c(ULA_c), .halt(halt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {PC_w,MEM_w,IR_w,RB_w,AB_w,MDR_w,M_WREG,M_ULAA,IorD,M_REGDATA,M_ULAB,ULA_c,halt}
    assign outs = {PC_w, MEM_w, IR_w, RB_w, AB_w, MDR_w, M_WREG, M_ULAA, IorD, M_REGDATA, M_ULAB, ULA_c, halt};

    localparam logic [5:0]  G         = 6'h3F;
    localparam logic [15:0] O_NONE    = 16'h0000;
    localparam logic [15:0] O_FETCH   = {1'b1, 9'b0, 2'b01, 3'b001, 1'b0};
    localparam logic [15:0] O_IRLD    = {3'b001, 7'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_DEC     = {4'b0000, 1'b1, 5'b0, 6'b0};
    localparam logic [15:0] O_ADD     = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b001, 1'b0};
    localparam logic [15:0] O_ADD_OF  = {3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b001, 1'b0};
    localparam logic [15:0] O_SUB     = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] O_AND     = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0};
    localparam logic [15:0] O_RBAD    = {3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_ADDI    = {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b001, 1'b0};
    localparam logic [15:0] O_ADDI_OF = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b001, 1'b0};
    localparam logic [15:0] O_MADDR   = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 1'b0};
    localparam logic [15:0] O_MRW     = {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 1'b0};
    localparam logic [15:0] O_MWB     = {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_MWR     = {3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 1'b0};
    localparam logic [15:0] O_BCMP    = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b111, 1'b0};
    localparam logic [15:0] O_BT      = {1'b1, 9'b0, 2'b10, 3'b001, 1'b0};
    localparam logic [15:0] O_BN      = {1'b0, 9'b0, 2'b10, 3'b001, 1'b0};
    localparam logic [15:0] O_HALT    = 16'h0001;

    typedef struct {
        logic       rst;
        logic [5:0] opc;
        logic [5:0] fn;
        logic       of;
        logic       eq;
        logic [3:0] st;
        logic [15:0] out;
    } vec_t;
    vec_t vq[$];

    function automatic void row(input logic r, input logic [5:0] o, input logic [5:0] f,
                                input logic v, input logic e, input logic [3:0] s, input logic [15:0] x);
        vec_t t;
        t.rst = r; t.opc = o; t.fn = f; t.of = v; t.eq = e; t.st = s; t.out = x;
        vq.push_back(t);
    endfunction

    // garbage IR and flag values in states that must ignore them
    function automatic void fetch3();
        row(0, G, G, 1, 1, 4'd1, O_FETCH);
        row(0, G, G, 1, 1, 4'd2, O_NONE);
        row(0, G, G, 1, 1, 4'd3, O_IRLD);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic v, input logic e);
        @(negedge clk);
        reset = r; OPCODE = o; FUNCT = f; Of = v; Eq = e;
        #1;
    endtask

    task automatic to_decode(input logic [5:0] o, input logic [5:0] f);
        drive(1, G, G, 0, 0);
        drive(0, G, G, 0, 0);
        repeat (3) drive(0, G, G, 1, 1);
        drive(0, o, f, 0, 0);
        chk("to_decode state", 32'(state_dbg), 32'd4);
    endtask

    initial begin
        row(1, G, G, 0, 0, 4'd0, O_NONE);
        row(0, G, G, 0, 0, 4'd0, O_NONE);
        fetch3(); row(0, 6'h00, 6'h20, 0, 0, 4'd4, O_DEC); row(0, G, 6'h20, 0, 0, 4'd5, O_ADD);
        fetch3(); row(0, 6'h00, 6'h22, 0, 0, 4'd4, O_DEC); row(0, G, 6'h22, 0, 1, 4'd5, O_SUB);
        fetch3(); row(0, 6'h00, 6'h24, 0, 0, 4'd4, O_DEC); row(0, G, 6'h24, 1, 0, 4'd5, O_AND);
        fetch3(); row(0, 6'h08, G, 0, 0, 4'd4, O_DEC); row(0, G, G, 0, 0, 4'd6, O_ADDI);
        fetch3(); row(0, 6'h23, G, 0, 0, 4'd4, O_DEC);
        row(0, G, G, 1, 1, 4'd7, O_MADDR); row(0, G, G, 1, 1, 4'd8, O_MRW); row(0, G, G, 1, 1, 4'd9, O_MWB);
        fetch3(); row(0, 6'h2B, G, 0, 0, 4'd4, O_DEC); row(0, G, G, 1, 1, 4'd10, O_MWR);
        fetch3(); row(0, 6'h04, G, 0, 0, 4'd4, O_DEC); row(0, 6'h04, G, 0, 1, 4'd11, O_BCMP); row(0, G, G, 0, 0, 4'd12, O_BT);
        fetch3(); row(0, 6'h04, G, 0, 0, 4'd4, O_DEC); row(0, 6'h04, G, 0, 0, 4'd11, O_BCMP); row(0, G, G, 0, 1, 4'd12, O_BN);
        fetch3(); row(0, 6'h05, G, 0, 0, 4'd4, O_DEC); row(0, 6'h05, G, 0, 1, 4'd11, O_BCMP); row(0, G, G, 0, 0, 4'd12, O_BN);
        fetch3(); row(0, 6'h05, G, 0, 0, 4'd4, O_DEC); row(0, 6'h05, G, 0, 0, 4'd11, O_BCMP); row(0, G, G, 0, 1, 4'd12, O_BT);
        fetch3(); row(0, 6'h00, 6'h20, 0, 0, 4'd4, O_DEC); row(0, G, 6'h20, 1, 0, 4'd5, O_ADD_OF);
        row(0, G, G, 0, 0, 4'd15, O_HALT); row(0, G, G, 0, 0, 4'd15, O_HALT);
        row(1, G, G, 0, 0, 4'd15, O_HALT); row(0, G, G, 0, 0, 4'd0, O_NONE);
        fetch3(); row(0, 6'h00, G, 0, 0, 4'd4, O_DEC); row(0, G, G, 0, 0, 4'd5, O_RBAD);
        row(0, G, G, 0, 0, 4'd15, O_HALT); row(1, G, G, 0, 0, 4'd15, O_HALT); row(0, G, G, 0, 0, 4'd0, O_NONE);
        fetch3(); row(0, 6'h08, G, 0, 0, 4'd4, O_DEC); row(0, G, G, 1, 0, 4'd6, O_ADDI_OF);
        row(0, G, G, 0, 0, 4'd15, O_HALT); row(1, G, G, 0, 0, 4'd15, O_HALT); row(0, G, G, 0, 0, 4'd0, O_NONE);
        fetch3();

        repeat (3) @(posedge clk);
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].opc, vq[i].fn, vq[i].of, vq[i].eq);
            chk($sformatf("row%0d {state,outs}", i), {12'd0, state_dbg, outs}, {12'd0, vq[i].st, vq[i].out});
        end

        to_decode(6'h3F, 6'h20);
        for (int k = 0; k < 20; k++) begin
            drive(0, 6'h00, 6'h20, 0, 1);
            chk($sformatf("halt hold %0d", k), {27'd0, state_dbg, halt}, {27'd0, 4'd15, 1'b1});
        end
        drive(1, G, G, 0, 0);
        drive(0, G, G, 0, 0);
        chk("halt reset state", {12'd0, state_dbg, outs}, {12'd0, 4'd0, O_NONE});
        drive(0, G, G, 0, 0);
        chk("halt reset fetch", 32'(state_dbg), 32'd1);

        to_decode(6'h23, G);
        drive(0, G, G, 0, 0);
        chk("lw addr", 32'(state_dbg), 32'd7);
        drive(1, G, G, 0, 0);
        chk("lw rwait", {27'd0, state_dbg, MDR_w}, {27'd0, 4'd8, 1'b1});
        drive(1, G, G, 0, 0);
        chk("rwait reset", {11'd0, RB_w, state_dbg, outs}, {11'd0, 1'b0, 4'd0, O_NONE});
        drive(0, G, G, 0, 0);
        chk("rwait reset hold", {27'd0, RB_w, state_dbg}, {27'd0, 1'b0, 4'd0});
        drive(0, G, G, 0, 0);
        chk("rwait resume", {27'd0, RB_w, state_dbg}, {27'd0, 1'b0, 4'd1});

        to_decode(6'h2B, G);
        drive(1, G, G, 0, 0);
        chk("sw write under reset", {27'd0, state_dbg, MEM_w}, {27'd0, 4'd10, 1'b1});
        drive(0, G, G, 0, 0);
        chk("sw reset after", {12'd0, state_dbg, outs}, {12'd0, 4'd0, O_NONE});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
